wb_arbiter: RTL and testbench

Writeback arbiter that owns the single write port of the integer register file. It merges in-order pipeline results (port A, no backpressure) with out-of-order long-latency results (port B: divider, load-miss return; valid/ready) through a small queue. It drives `regwrite`/`rd`/`wdata` from registers. A starvation counter guarantees that queued port-B results drain under continuous port-A traffic.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/wb_fifo.sv | 80 ++++++++
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file geometry, the writeback entry record and
// the writeback arbiter's state encoding.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    ARB_RUN   = 1'b0,
    ARB_STALL = 1'b1
  } arb_state_t;

  // x0 is hardwired to zero, so writes addressed to it are dropped.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries with push/pop/count. With WB_BYPASS_EN
// defined it also exposes all entries, oldest first, for operand bypass.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t                  view_entry [DEPTH],
  output logic [DEPTH-1:0]           view_valid
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

`ifdef WB_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      view_entry[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      view_valid[i] = (CNT_W'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: in-order port A beats queued port B, with a
// starvation stall that forces a queued entry out. Optional WB_BYPASS_EN.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  input  logic [REG_ADDR_W-1:0]      a_rd,
  input  logic [XLEN-1:0]            a_data,
  output logic                       a_stall,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [REG_ADDR_W-1:0]      b_rd,
  input  logic [XLEN-1:0]            b_data,
  output logic                       regwrite,
  output logic [REG_ADDR_W-1:0]      rd,
  output logic [XLEN-1:0]            wdata,
  output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0]      byp_rs1,
  input  logic [REG_ADDR_W-1:0]      byp_rs2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [XLEN-1:0]            byp_data1,
  output logic [XLEN-1:0]            byp_data2
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, a_win;
  arb_state_t            state_q, state_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;

`ifdef WB_BYPASS_EN
  wb_entry_t             view_entry [DEPTH];
  logic [DEPTH-1:0]      view_valid;
`endif

  assign push_entry = '{rd: b_rd, data: b_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (q_count)
`ifdef WB_BYPASS_EN
    ,
    .view_entry (view_entry),
    .view_valid (view_valid)
`endif
  );

  // Port A wins unless stalled; an empty queue never feeds the same cycle it fills.
  always_comb begin
    a_win      = a_valid && (state_q != ARB_STALL);
    pop        = !a_win && !fifo_empty;
    push       = b_valid && b_ready && writes_reg(b_rd);
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (a_win) begin
      regwrite_d = writes_reg(a_rd);
      rd_d       = a_rd;
      wdata_d    = a_data;
    end else if (pop) begin
      regwrite_d = 1'b1;
      rd_d       = head.rd;
      wdata_d    = head.data;
    end

    starve_cnt_d = starve_cnt_q;
    if (pop || fifo_empty) begin
      starve_cnt_d = '0;
    end else if (a_win) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
    state_d = (starve_cnt_d == SC_W'(STARVE_LIMIT)) ? ARB_STALL : ARB_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_RUN;
      starve_cnt_q <= '0;
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
    end
  end

  assign a_stall  = (state_q == ARB_STALL);
  assign b_ready  = !fifo_full;
  assign regwrite = regwrite_q;
  assign rd       = rd_q;
  assign wdata    = wdata_q;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match (the youngest) is the one kept.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    if (regwrite_q && writes_reg(byp_rs1) && rd_q == byp_rs1) begin
      byp_hit1  = 1'b1;
      byp_data1 = wdata_q;
    end
    if (regwrite_q && writes_reg(byp_rs2) && rd_q == byp_rs2) begin
      byp_hit2  = 1'b1;
      byp_data2 = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (view_valid[i] && writes_reg(byp_rs1) && view_entry[i].rd == byp_rs1) begin
        byp_hit1  = 1'b1;
        byp_data1 = view_entry[i].data;
      end
      if (view_valid[i] && writes_reg(byp_rs2) && view_entry[i].rd == byp_rs2) begin
        byp_hit2  = 1'b1;
        byp_data2 = view_entry[i].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter with a write scoreboard; build with
// WB_BYPASS_EN defined to include the bypass-port checks.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [2:0]  q_count;
`ifdef WB_BYPASS_EN
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_stall   (a_stall),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .regwrite  (regwrite),
    .rd        (rd),
    .wdata     (wdata),
    .q_count   (q_count)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  // Every register-file write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got rd=%0d wdata=%h, required no write", rd, wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rd, wdata} !== mon_exp) begin
          errors++;
          $display("[TB] FAIL write_seq: got rd=%0d wdata=%h, required rd=%0d wdata=%h",
                   rd, wdata, mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic av, input int ard, input logic [31:0] adata,
                               input logic bv, input int brd, input logic [31:0] bdata,
                               input logic ew, input int erd, input logic [31:0] edata);
    a_valid = av;
    a_rd    = 5'(ard);
    a_data  = adata;
    b_valid = bv;
    b_rd    = 5'(brd);
    b_data  = bdata;
    if (ew) exp_q.push_back({5'(erd), edata});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    a_rd    = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_rd    = '0;
    b_data  = '0;
`ifdef WB_BYPASS_EN
    byp_rs1 = '0;
    byp_rs2 = '0;
`endif
    idle();
    idle();
    rst = 1'b0;
    checkOutput("rst_regwrite", 32'(regwrite), 32'd0);
    checkOutput("rst_rd", 32'(rd), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_a_stall", 32'(a_stall), 32'd0);
    checkOutput("rst_b_ready", 32'(b_ready), 32'd1);
    checkOutput("rst_q_count", 32'(q_count), 32'd0);

    $display("[TB] single port-A write");
    applyStimulus(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b1, 5, 32'hDEADBEEF);
    checkOutput("a_regwrite", 32'(regwrite), 32'd1);
    checkOutput("a_rd", 32'(rd), 32'd5);
    checkOutput("a_wdata", wdata, 32'hDEADBEEF);
    idle();
    checkOutput("a_after_regwrite", 32'(regwrite), 32'd0);

    $display("[TB] two port-B writes, port A idle");
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 3, 32'h11, 1'b0, 0, 32'h0);
    checkOutput("b_no_fallthrough", 32'(regwrite), 32'd0);
    checkOutput("b_count1", 32'(q_count), 32'd1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 4, 32'h22, 1'b1, 3, 32'h11);
    checkOutput("b_rd3", 32'(rd), 32'd3);
    checkOutput("b_count_pushpop", 32'(q_count), 32'd1);
    applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 4, 32'h22);
    checkOutput("b_rd4", 32'(rd), 32'd4);
    checkOutput("b_count0", 32'(q_count), 32'd0);
    idle();

    $display("[TB] fill queue under port-A traffic");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 20 + i, 32'h100 + i, 1'b1, 10 + i, 32'hA0 + i, 1'b1, 20 + i, 32'h100 + i);
    checkOutput("full_count", 32'(q_count), 32'd4);
    checkOutput("full_b_ready", 32'(b_ready), 32'd0);
    applyStimulus(1'b1, 24, 32'h104, 1'b1, 14, 32'hA4, 1'b1, 24, 32'h104);
    checkOutput("full_held_count", 32'(q_count), 32'd4);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 14, 32'hA4, 1'b1, 10, 32'hA0);
    checkOutput("full_pop_count", 32'(q_count), 32'd3);
    checkOutput("full_b_ready_rise", 32'(b_ready), 32'd1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 14, 32'hA4, 1'b1, 11, 32'hA1);
    checkOutput("held_accepted_count", 32'(q_count), 32'd3);
    applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 12, 32'hA2);
    applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 13, 32'hA3);
    applyStimulus(1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 14, 32'hA4);
    checkOutput("drain_count", 32'(q_count), 32'd0);
    idle();

    $display("[TB] starvation stall");
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 7, 32'h77, 1'b0, 0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8 + i, 32'h200 + i, 1'b0, 0, 32'h0, 1'b1, 8 + i, 32'h200 + i);
      if (i == 6) checkOutput("starve_no_stall_yet", 32'(a_stall), 32'd0);
    end
    checkOutput("starve_stall", 32'(a_stall), 32'd1);
    applyStimulus(1'b1, 16, 32'h208, 1'b0, 0, 32'h0, 1'b1, 7, 32'h77);
    checkOutput("starve_stall_one_cycle", 32'(a_stall), 32'd0);
    checkOutput("starve_b_out", 32'(rd), 32'd7);
    checkOutput("starve_count0", 32'(q_count), 32'd0);
    applyStimulus(1'b1, 16, 32'h208, 1'b0, 0, 32'h0, 1'b1, 16, 32'h208);
    checkOutput("starve_a_resumes", 32'(rd), 32'd16);
    idle();

    $display("[TB] x0 destinations");
    applyStimulus(1'b1, 0, 32'h99, 1'b1, 0, 32'h55, 1'b0, 0, 32'h0);
    checkOutput("x0_count", 32'(q_count), 32'd0);
    checkOutput("x0_regwrite", 32'(regwrite), 32'd0);
    checkOutput("x0_b_ready", 32'(b_ready), 32'd1);

    $display("[TB] reset with queued entries");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1 + i, 32'h300 + i, 1'b1, 25 + i, 32'h400 + i, 1'b1, 1 + i, 32'h300 + i);
    checkOutput("pre_rst_count", 32'(q_count), 32'd3);
`ifdef WB_BYPASS_EN
    byp_rs1 = 5'd26;
    byp_rs2 = 5'd3;
    #1;
    checkOutput("byp_q_hit", 32'(byp_hit1), 32'd1);
    checkOutput("byp_q_data", byp_data1, 32'h401);
    checkOutput("byp_out_hit", 32'(byp_hit2), 32'd1);
    checkOutput("byp_out_data", byp_data2, 32'h302);
`endif
    rst = 1'b1;
    applyStimulus(1'b1, 9, 32'h999, 1'b1, 28, 32'h428, 1'b0, 0, 32'h0);
    rst = 1'b0;
    checkOutput("midrst_count", 32'(q_count), 32'd0);
    checkOutput("midrst_regwrite", 32'(regwrite), 32'd0);
    checkOutput("midrst_b_ready", 32'(b_ready), 32'd1);
    checkOutput("midrst_a_stall", 32'(a_stall), 32'd0);
`ifdef WB_BYPASS_EN
    for (int r = 0; r < 32; r++) begin
      byp_rs1 = 5'(r);
      #1;
      checkOutput("midrst_byp_hit1", 32'(byp_hit1), 32'd0);
    end
`endif
    idle();
    idle();
    idle();
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
